// File: rtl/control_fsm_if.sv
// Memory request/ready handshake between the multicycle control FSM and memory.
interface control_fsm_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/control_fsm.sv
// Multicycle RV32 control FSM: state register plus decoded control strobes.
// Define CONTROL_FSM_CSR_EN to add the CSR write state for opcode 1110011.
module control_fsm (
  input  logic                 clk,
  input  logic                 resetn,
  control_fsm_if.master        mem,
  input  logic [31:0]          instr,
  input  logic                 branch_taken,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 csr_write,
  output logic                 illegal,
  output logic [3:0]           state
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OPC_W   = 7;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13
`ifdef CONTROL_FSM_CSR_EN
    , S_CSR    = 4'd14
`endif
  } state_e;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
`ifdef CONTROL_FSM_CSR_EN
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
`endif

  localparam logic [1:0] A_PC     = 2'd0;
  localparam logic [1:0] A_OLDPC  = 2'd1;
  localparam logic [1:0] A_RS1    = 2'd2;
  localparam logic [1:0] A_ZERO   = 2'd3;
  localparam logic [1:0] B_RS2    = 2'd0;
  localparam logic [1:0] B_IMM    = 2'd1;
  localparam logic [1:0] B_FOUR   = 2'd2;
  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_BRCMP = 2'd1;
  localparam logic [1:0] OP_FUNCT = 2'd2;
  localparam logic [1:0] RES_AOUT = 2'd0;
  localparam logic [1:0] RES_MEM  = 2'd1;
  localparam logic [1:0] RES_ALU  = 2'd2;

  state_e           state_q, state_d;
  logic             jalr_ph_q, jalr_ph_d;
  logic [OPC_W-1:0] opcode;
  logic             unused_instr;

  assign opcode       = instr[OPC_W-1:0];
  assign unused_instr = ^instr[31:OPC_W];
  assign state        = state_q;

  // State and JALR phase registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_FETCH;
      jalr_ph_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      jalr_ph_q <= jalr_ph_d;
    end
  end

  // Next state and control strobes; everything is forced low while in reset.
  always_comb begin
    state_d       = S_FETCH;
    jalr_ph_d     = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_write = 1'b0;
    mem.adr_src   = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = A_PC;
    alu_src_b     = B_RS2;
    alu_op        = OP_ADD;
    result_src    = RES_AOUT;
    csr_write     = 1'b0;
    illegal       = 1'b0;
    if (resetn) begin
      case (state_q)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_a  = A_PC;
            alu_src_b  = B_FOUR;
            alu_op     = OP_ADD;
            result_src = RES_ALU;
            state_d    = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_a = A_OLDPC;
          alu_src_b = B_IMM;
          alu_op    = OP_ADD;
          case (opcode)
            OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
            OPC_RTYPE:           state_d = S_EXECR;
            OPC_ITYPE:           state_d = S_EXECI;
            OPC_BRANCH:          state_d = S_BRANCH;
            OPC_JAL:             state_d = S_JAL;
            OPC_JALR:            state_d = S_JALR;
            OPC_LUI:             state_d = S_LUI;
            OPC_AUIPC:           state_d = S_AUIPC;
`ifdef CONTROL_FSM_CSR_EN
            OPC_SYSTEM:          state_d = S_CSR;
`endif
            default:             illegal = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = A_RS1;
          alu_src_b = B_IMM;
          alu_op    = OP_ADD;
          if (opcode == OPC_LOAD) begin
            state_d = S_MEMREAD;
          end else if (opcode == OPC_STORE) begin
            state_d = S_MEMWRITE;
          end
        end
        S_MEMREAD: begin
          mem.mem_req = 1'b1;
          mem.adr_src = 1'b1;
          state_d     = mem.mem_ready ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWRITE: begin
          mem.mem_req   = 1'b1;
          mem.mem_write = 1'b1;
          mem.adr_src   = 1'b1;
          state_d       = mem.mem_ready ? S_FETCH : S_MEMWRITE;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = RES_MEM;
        end
        S_EXECR: begin
          alu_src_a = A_RS1;
          alu_src_b = B_RS2;
          alu_op    = OP_FUNCT;
          state_d   = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a = A_RS1;
          alu_src_b = B_IMM;
          alu_op    = OP_FUNCT;
          state_d   = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          result_src = RES_AOUT;
        end
        S_BRANCH: begin
          alu_src_a = A_RS1;
          alu_src_b = B_RS2;
          alu_op    = OP_BRCMP;
          if (branch_taken) begin
            pc_write   = 1'b1;
            result_src = RES_AOUT;
          end
        end
        // Target comes from the DECODE result; ALU meanwhile forms old PC+4 for the link.
        S_JAL: begin
          pc_write   = 1'b1;
          result_src = RES_AOUT;
          alu_src_a  = A_OLDPC;
          alu_src_b  = B_FOUR;
          alu_op     = OP_ADD;
          state_d    = S_ALUWB;
        end
        // Phase 0 redirects PC to rs1+imm; phase 1 forms old PC+4 for the link.
        S_JALR: begin
          alu_op = OP_ADD;
          if (!jalr_ph_q) begin
            alu_src_a  = A_RS1;
            alu_src_b  = B_IMM;
            pc_write   = 1'b1;
            result_src = RES_ALU;
            jalr_ph_d  = 1'b1;
            state_d    = S_JALR;
          end else begin
            alu_src_a = A_OLDPC;
            alu_src_b = B_FOUR;
            state_d   = S_ALUWB;
          end
        end
        S_LUI: begin
          alu_src_a = A_ZERO;
          alu_src_b = B_IMM;
          state_d   = S_ALUWB;
        end
        S_AUIPC: begin
          alu_src_a = A_OLDPC;
          alu_src_b = B_IMM;
          state_d   = S_ALUWB;
        end
`ifdef CONTROL_FSM_CSR_EN
        S_CSR: begin
          csr_write  = 1'b1;
          reg_write  = 1'b1;
          result_src = RES_ALU;
        end
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- instr  in  32  instruction register contents; opcode is instr[6:0].
- mem_ready  in  1  memory completes the current request this cycle.
- branch_taken  in  1  branch comparator result for the current instr.
- mem_req  out  1  memory request, held until mem_ready.
- mem_write  out  1  request is a store.
- adr_src  out  1  memory address select: 0=PC, 1=ALU out reg.
- ir_write  out  1  latch fetched word into instruction register and old PC.
- pc_write  out  1  update PC from ALU result.
- reg_write  out  1  register file write.
- alu_src_a  out  2  ALU A select: 0=PC, 1=old PC, 2=rs1, 3=zero.
- alu_src_b  out  2  ALU B select: 0=rs2, 1=imm_ext, 2=const 4.
- alu_op  out  2  ALU op class: 0=add, 1=branch compare, 2=funct decode.
- result_src  out  2  writeback select: 0=ALU out reg, 1=mem data, 2=ALU result.
- csr_write  out  1  CSR file write strobe.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state code, for debug.

Function
REQ-003 The state encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13, CSR=14.
REQ-004 FETCH:
- Drive mem_req=1, adr_src=0.
- Stay in FETCH while mem_ready=0.
- On the cycle mem_ready=1, assert ir_write=1 and pc_write=1 with alu_src_a=0, alu_src_b=2, alu_op=0, result_src=2, then go to DECODE.
REQ-005 DECODE SHALL compute the branch target (alu_src_a=1, alu_src_b=1, alu_op=0) and branch on opcode:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- 0110111 -> LUI
- 0010111 -> AUIPC
- 1110011 -> CSR
- any other opcode -> FETCH, with illegal=1 for exactly that cycle.
REQ-006 MEMADR SHALL use alu_src_a=2, alu_src_b=1, alu_op=0, and go to MEMREAD for opcode 0000011 or MEMWRITE for 0100011.
REQ-007 MEMREAD and MEMWRITE SHALL drive mem_req=1 and adr_src=1 (MEMWRITE also mem_write=1), holding until mem_ready=1.
- On mem_ready=1, MEMREAD goes to MEMWB and MEMWRITE goes to FETCH.
REQ-008 MEMWB SHALL assert reg_write=1 with result_src=1, then go to FETCH.
REQ-009 EXECR SHALL use alu_src_a=2, alu_src_b=0, alu_op=2. EXECI SHALL use alu_src_a=2, alu_src_b=1, alu_op=2. Both go to ALUWB.
REQ-010 ALUWB SHALL assert reg_write=1 with result_src=0, then go to FETCH.
REQ-011 BRANCH SHALL use alu_src_a=2, alu_src_b=0, alu_op=1, and assert pc_write=1 with result_src=0 only when branch_taken=1, then go to FETCH.
REQ-012 JAL SHALL assert pc_write=1 with result_src=0, then go to ALUWB.
- Entering ALUWB, the ALU out register SHALL hold old PC+4, computed with alu_src_a=1, alu_src_b=2.
REQ-013 JALR SHALL compute rs1+imm (alu_src_a=2, alu_src_b=1) and assert pc_write=1 with result_src=2, then go to ALUWB.
- JALR SHALL run as a 2-cycle sequence using an internal phase bit so that ALUWB writes old PC+4.
REQ-014 LUI SHALL use alu_src_a=3, alu_src_b=1. AUIPC SHALL use alu_src_a=1, alu_src_b=1. Both go to ALUWB.
REQ-015 mem_req SHALL be 0 in every state other than FETCH, MEMREAD and MEMWRITE.
REQ-016 mem_ready SHALL be ignored while mem_req=0.
REQ-017 Every output not driven by a state SHALL be 0.
REQ-018 Latency with zero-wait memory SHALL be:
- R-type: 4 cycles
- load: 5 cycles
- store: 4 cycles
- branch: 3 cycles
- Each mem_ready wait cycle adds 1 cycle.
REQ-019 State codes 15 and unused values SHALL recover to FETCH on the next clock.

Reset
REQ-020 resetn=0 SHALL immediately force state=FETCH, clear the JALR phase bit, and drive every output to 0 except state=0.
REQ-021 Reset asserted mid-transaction (including while mem_req=1) SHALL abort the transaction, with no pc_write, reg_write or ir_write.
REQ-022 After reset release, the first clock edge SHALL find the block in FETCH with mem_req=1.

Configuration
REQ-023 Macro CONTROL_FSM_CSR_EN:
- When defined, opcode 1110011 SHALL enter CSR, which asserts csr_write=1 and reg_write=1 with result_src=2 for one cycle, then goes to FETCH.
- When undefined, the CSR state SHALL not exist, 1110011 SHALL be treated as illegal (REQ-005), and csr_write SHALL be tied to 0.

Verification
REQ-024 Reset, release, mem_ready=1 constantly, instr=0x00A00093 (addi) -> state sequence 0,1,7,8,0, with reg_write=1 only in state 8.
REQ-025 instr=0x0000A103 (lw), mem_ready low for 3 cycles in MEMREAD -> mem_req=1 and adr_src=1 held 4 cycles, then MEMWB with result_src=1 and reg_write=1.
REQ-026 instr=0x00208463 (beq): branch_taken=0 -> no pc_write in BRANCH; branch_taken=1 -> pc_write=1 in BRANCH.
REQ-027 instr=0xFFFFFFFF -> illegal=1 for 1 cycle in DECODE, next state 0, no reg_write.
REQ-028 resetn pulled low during MEMWRITE with mem_ready=0 -> state=0 and mem_req=mem_write=0 in the same cycle.
REQ-029 instr=0x30001073 (csrw) -> with CONTROL_FSM_CSR_EN defined, csr_write=1 for 1 cycle; without it, illegal=1.
